// File: rtl/patch_router_if.sv
// Audio crossbar bus: strobe, dry/effect samples, route selects, routed outputs.
// Latency: n/a (wires only).
// Backpressure: none; the sample strobe is a push-only valid.
interface patch_router_if #(
    parameter int SAMPLE_W = 16
);
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] dry_in;
    logic signed [SAMPLE_W-1:0] crush_out;
    logic signed [SAMPLE_W-1:0] distortion_out;
    logic signed [SAMPLE_W-1:0] filter_out;
    logic signed [SAMPLE_W-1:0] reverb_out;
    logic signed [SAMPLE_W-1:0] delay_out;
    logic [2:0]                 output_src;
    logic [2:0]                 crush_src;
    logic [2:0]                 distortion_src;
    logic [2:0]                 filter_src;
    logic [2:0]                 reverb_src;
    logic [2:0]                 delay_src;
    logic signed [SAMPLE_W-1:0] crush_in;
    logic signed [SAMPLE_W-1:0] distortion_in;
    logic signed [SAMPLE_W-1:0] filter_in;
    logic signed [SAMPLE_W-1:0] reverb_in;
    logic signed [SAMPLE_W-1:0] delay_in;
    logic signed [SAMPLE_W-1:0] audio_out;
    logic                       out_valid;
    logic                       fading;

    modport master (
        output sample_valid, dry_in, crush_out, distortion_out, filter_out, reverb_out, delay_out,
        output output_src, crush_src, distortion_src, filter_src, reverb_src, delay_src,
        input  crush_in, distortion_in, filter_in, reverb_in, delay_in, audio_out, out_valid, fading
    );

    modport slave (
        input  sample_valid, dry_in, crush_out, distortion_out, filter_out, reverb_out, delay_out,
        input  output_src, crush_src, distortion_src, filter_src, reverb_src, delay_src,
        output crush_in, distortion_in, filter_in, reverb_in, delay_in, audio_out, out_valid, fading
    );
endinterface

// File: rtl/patch_router.sv
// Click-free audio crossbar: routes dry/effect samples to effect inputs and a gain-faded output.
// Latency: 1 clk from sample_valid to registered outputs (out_valid pulse).
// Backpressure: none; route changes are deferred through a fade-out/switch/fade-in sequence.
module patch_router #(
    parameter int SAMPLE_W  = 16,
    parameter int FADE_LOG2 = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    patch_router_if.slave bus
);
    localparam int GW = FADE_LOG2 + 1;
    localparam int PW = SAMPLE_W + FADE_LOG2 + 1;
    localparam logic [GW-1:0] GAIN_MAX = {1'b1, {FADE_LOG2{1'b0}}};
    localparam logic [GW-1:0] GAIN_ONE = {{FADE_LOG2{1'b0}}, 1'b1};

    // Route slot indices into the applied/live select arrays.
    localparam int OUT   = 0;
    localparam int CRUSH = 1;
    localparam int DIST  = 2;
    localparam int FILT  = 3;
    localparam int REV   = 4;
    localparam int DLY   = 5;

    typedef enum logic [1:0] {IDLE, FADE_OUT, SWITCH, FADE_IN} state_t;

    state_t                     r_state;
    logic                       r_fading;
    logic [GW-1:0]              r_gain;
    logic [2:0]                 r_app [6];
    logic signed [SAMPLE_W-1:0] r_crush_in, r_dist_in, r_filt_in, r_rev_in, r_dly_in, r_audio;
    logic                       r_out_valid;

    logic [2:0]                 w_live [6];
    logic signed [SAMPLE_W-1:0] w_pool [8];
    logic signed [SAMPLE_W-1:0] w_mux  [6];
    logic                       w_mismatch;
    logic signed [PW-1:0]       w_prod;
    logic signed [SAMPLE_W-1:0] w_scaled;

    // Code 6 is illegal and behaves exactly like 7 (not in chain).
    function automatic logic [2:0] legalise(input logic [2:0] s);
        return (s == 3'd6) ? 3'd7 : s;
    endfunction

    assign w_live[OUT]   = legalise(bus.output_src);
    assign w_live[CRUSH] = legalise(bus.crush_src);
    assign w_live[DIST]  = legalise(bus.distortion_src);
    assign w_live[FILT]  = legalise(bus.filter_src);
    assign w_live[REV]   = legalise(bus.reverb_src);
    assign w_live[DLY]   = legalise(bus.delay_src);

    assign w_pool[0] = bus.dry_in;
    assign w_pool[1] = bus.delay_out;
    assign w_pool[2] = bus.reverb_out;
    assign w_pool[3] = bus.filter_out;
    assign w_pool[4] = bus.distortion_out;
    assign w_pool[5] = bus.crush_out;
    assign w_pool[6] = '0;
    assign w_pool[7] = '0;

    for (genvar i = 0; i < 6; i++) begin : g_mux
        assign w_mux[i] = w_pool[r_app[i]];
    end

    // Any live route differing from the applied one requests a fade sequence.
    always_comb begin
        w_mismatch = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (w_live[i] != r_app[i]) w_mismatch = 1'b1;
        end
    end

    // Signed sample times unsigned gain; the arithmetic shift undoes the gain scale exactly at max.
    assign w_prod   = PW'(w_mux[OUT]) * $signed(PW'({1'b0, r_gain}));
    assign w_scaled = SAMPLE_W'(w_prod >>> FADE_LOG2);

    // Fade sequencer: gain steps once per sample, the route snapshot happens only at silence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_fading <= 1'b0;
            r_gain   <= GAIN_MAX;
            r_app[OUT] <= 3'd0;
            for (int i = 1; i < 6; i++) r_app[i] <= 3'd7;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mismatch) begin
                        r_state  <= FADE_OUT;
                        r_fading <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (r_gain == '0) begin
                        r_state <= SWITCH;
                    end else if (bus.sample_valid) begin
                        r_gain <= r_gain - GAIN_ONE;
                        if (r_gain == GAIN_ONE) r_state <= SWITCH;
                    end
                end
                SWITCH: begin
                    for (int i = 0; i < 6; i++) r_app[i] <= w_live[i];
                    r_state <= FADE_IN;
                end
                FADE_IN: begin
                    if (w_mismatch) begin
                        // Reverse direction from wherever the ramp currently is.
                        r_state <= FADE_OUT;
                        if (bus.sample_valid && r_gain != '0) r_gain <= r_gain - GAIN_ONE;
                    end else if (r_gain == GAIN_MAX) begin
                        r_state  <= IDLE;
                        r_fading <= 1'b0;
                    end else if (bus.sample_valid) begin
                        r_gain <= r_gain + GAIN_ONE;
                        if (r_gain == GAIN_MAX - GAIN_ONE) begin
                            r_state  <= IDLE;
                            r_fading <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_fading <= 1'b0;
                end
            endcase
        end
    end

    // Sample datapath: capture routed samples and the faded output on each strobe, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crush_in  <= '0;
            r_dist_in   <= '0;
            r_filt_in   <= '0;
            r_rev_in    <= '0;
            r_dly_in    <= '0;
            r_audio     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.sample_valid;
            if (bus.sample_valid) begin
                r_crush_in <= w_mux[CRUSH];
                r_dist_in  <= w_mux[DIST];
                r_filt_in  <= w_mux[FILT];
                r_rev_in   <= w_mux[REV];
                r_dly_in   <= w_mux[DLY];
                r_audio    <= w_scaled;
            end
        end
    end

    assign bus.crush_in      = r_crush_in;
    assign bus.distortion_in = r_dist_in;
    assign bus.filter_in     = r_filt_in;
    assign bus.reverb_in     = r_rev_in;
    assign bus.delay_in      = r_dly_in;
    assign bus.audio_out     = r_audio;
    assign bus.out_valid     = r_out_valid;
    assign bus.fading        = r_fading;
endmodule
